// File: rtl/aha_uart_pkg.sv
// aha_uart_pkg: shared FSM states and framing constants for the UART transmitter
package aha_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  localparam int MIN_BAUDDIV = 16;
  localparam int FRAME_BITS = 10;
endpackage

// File: rtl/aha_sync_fifo.sv
// aha_sync_fifo: single-clock byte queue with push/pop handshake and occupancy count
module aha_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic w_push, w_pop;
  assign o_full = r_level == LW'(DEPTH);
  assign o_empty = r_level == '0;
  assign o_level = r_level;
  assign o_data = r_mem[r_rptr];
  assign w_push = i_push & !o_full;
  assign w_pop = i_pop & !o_empty;
  // Storage array; contents are only meaningful below the level count, so no reset
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wptr] <= i_data;
  // Pointers wrap naturally at DEPTH; a simultaneous push and pop leaves the level unchanged
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
endmodule

// File: rtl/aha_uart_tx_driver.sv
// aha_uart_tx_driver: 8N1 UART transmitter fed from a small byte FIFO, LSB first
module aha_uart_tx_driver
  import aha_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH = 20
) (
  input  logic                          CLK,
  input  logic                          RESETn,
  input  logic                          ENABLE,
  input  logic [DIV_WIDTH-1:0]          BAUDDIV,
  input  logic                          IN_VALID,
  input  logic [7:0]                    IN_DATA,
  output logic                          IN_READY,
  output logic                          TXD,
  output logic                          BUSY,
  output logic                          TX_DONE,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  tx_state_e r_state, w_nstate;
  logic [DIV_WIDTH-1:0] r_div, r_cnt, w_ndiv, w_ncnt, w_div_eff;
  logic [2:0] r_bit, w_nbit;
  logic [7:0] r_shift, w_nshift, w_head;
  logic r_txd, r_done, w_ntxd, w_last, w_start, w_full, w_empty;
  logic [LW-1:0] w_level;

  assign w_div_eff = (BAUDDIV < DIV_WIDTH'(MIN_BAUDDIV)) ? DIV_WIDTH'(MIN_BAUDDIV) : BAUDDIV;
  assign w_last = r_cnt == '0;
  assign w_start = ENABLE & !w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_last));
  assign IN_READY = !w_full;
  assign TXD = r_txd;
  assign TX_DONE = r_done;
  assign FIFO_LEVEL = w_level;
  assign BUSY = (r_state != IDLE) | (w_level != '0);

  aha_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RESETn),
    .i_push  (IN_VALID),
    .i_pop   (w_start),
    .i_data  (IN_DATA),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Next state plus divider, bit counter and shifter; TXD is registered from the next state
  always_comb begin
    w_nstate = r_state;
    w_ncnt = (r_state == IDLE) ? r_cnt : (w_last ? r_div - DIV_WIDTH'(1) : r_cnt - DIV_WIDTH'(1));
    w_nbit = r_bit;
    w_nshift = r_shift;
    w_ndiv = r_div;
    if (w_last && r_state == START) begin
      w_nstate = DATA;
      w_nbit = '0;
    end
    if (w_last && r_state == DATA) begin
      w_nshift = r_shift >> 1;
      w_nbit = r_bit + 3'd1;
      w_nstate = (r_bit == 3'(FRAME_BITS - 3)) ? STOP : DATA;
    end
    if (w_last && r_state == STOP) w_nstate = IDLE;
    if (w_start) begin
      w_nstate = START;
      w_nshift = w_head;
      w_ndiv = w_div_eff;
      w_ncnt = w_div_eff - DIV_WIDTH'(1);
    end
    w_ntxd = (w_nstate == START) ? 1'b0 : (w_nstate == DATA) ? w_nshift[0] : 1'b1;
  end

  // State and datapath registers; reset drops the frame and idles the line at once
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_div <= DIV_WIDTH'(MIN_BAUDDIV);
      r_bit <= '0;
      r_shift <= '0;
      r_txd <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt <= w_ncnt;
      r_div <= w_ndiv;
      r_bit <= w_nbit;
      r_shift <= w_nshift;
      r_txd <= w_ntxd;
      r_done <= (r_state == STOP) & w_last;
    end
endmodule

// File: tb/tb_aha_uart_tx_driver.sv
// tb_aha_uart_tx_driver: directed vector bench for the UART transmitter
module tb_aha_uart_tx_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b1;
  logic [19:0] baud = 20'd16;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, txd, busy, tx_done;
  logic [2:0] level;
  int n_total = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] data;
    logic [19:0] bauddiv;
    int div;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[5];

  aha_uart_tx_driver #(.FIFO_DEPTH(4), .DIV_WIDTH(20)) dut (
    .CLK        (clk),
    .RESETn     (rst_n),
    .ENABLE     (en),
    .BAUDDIV    (baud),
    .IN_VALID   (in_valid),
    .IN_DATA    (in_data),
    .IN_READY   (in_ready),
    .TXD        (txd),
    .BUSY       (busy),
    .TX_DONE    (tx_done),
    .FIFO_LEVEL (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
  endtask

  // Call right after the start edge; samples each bit at its first, middle and last cycle
  task automatic run_frame(input logic [9:0] exp, input int div, input logic prev_done,
                           input string nm, output logic [7:0] got_byte);
    logic [9:0] first_v, mid_v, last_v;
    int dones;
    dones = 0;
    first_v = '0;
    mid_v = '0;
    last_v = '0;
    for (int c = 0; c < 10 * div; c++) begin
      @(negedge clk);
      if (c == 0) check({nm, " done@start"}, 32'(tx_done), 32'(prev_done));
      else if (tx_done) dones++;
      if (c % div == 0) first_v[c / div] = txd;
      if (c % div == div / 2) mid_v[c / div] = txd;
      if (c % div == div - 1) last_v[c / div] = txd;
    end
    check({nm, " bit-first"}, 32'(first_v), 32'(exp));
    check({nm, " bit-last"}, 32'(last_v), 32'(exp));
    check({nm, " early-done"}, 32'(dones), 32'd0);
    got_byte = mid_v[8:1];
  endtask

  task automatic frame_end(input string nm, input logic exp_busy);
    @(negedge clk);
    check({nm, " done-pulse"}, 32'(tx_done), 32'd1);
    check({nm, " idle-txd"}, 32'(txd), 32'd1);
    check({nm, " busy"}, 32'(busy), 32'(exp_busy));
  endtask

  task automatic push2(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = a;
    @(posedge clk);
    #1 in_data = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] msg[5];
    int exp_lvl[5];
    int lows;
    vecs[0] = '{8'hA5, 20'd16, 16, 10'h34A};
    vecs[1] = '{8'h00, 20'd3, 16, 10'h200};
    vecs[2] = '{8'hFF, 20'd20, 20, 10'h3FE};
    vecs[3] = '{8'h3C, 20'd0, 16, 10'h278};
    vecs[4] = '{8'h55, 20'd17, 17, 10'h2AA};
    msg = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    exp_lvl = '{1, 1, 2, 3, 4};

    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset txd", 32'(txd), 32'd1);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset level", 32'(level), 32'd0);
    check("reset tx_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      baud = vecs[i].bauddiv;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = vecs[i].data;
      @(posedge clk);
      #1 in_valid = 1'b0;
      check($sformatf("vec%0d pre-start txd", i), 32'(txd), 32'd1);
      check($sformatf("vec%0d queued", i), 32'(level), 32'd1);
      @(posedge clk);
      run_frame(vecs[i].frame, vecs[i].div, 1'b0, $sformatf("vec%0d", i), got);
      check($sformatf("vec%0d decoded", i), 32'(got), 32'(vecs[i].data));
      frame_end($sformatf("vec%0d", i), 1'b0);
    end

    baud = 20'd16;
    fork
      begin
        @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
          in_data = msg[i];
          @(posedge clk);
          #1;
          check($sformatf("b2b level after push%0d", i), 32'(level), 32'(exp_lvl[i]));
          check($sformatf("b2b ready after push%0d", i), 32'(in_ready), 32'(i < 4));
        end
        in_valid = 1'b0;
      end
      begin
        @(negedge clk);
        @(posedge clk);
        @(posedge clk);
        for (int j = 0; j < 5; j++) begin
          run_frame({1'b1, msg[j], 1'b0}, 16, j > 0, $sformatf("b2b frame%0d", j), got);
          check($sformatf("b2b byte%0d", j), 32'(got), 32'(msg[j]));
        end
      end
    join
    frame_end("b2b last", 1'b0);
    check("b2b drained", 32'(level), 32'd0);

    push2(8'h12, 8'h34);
    check("gate queued", 32'(level), 32'd1);
    fork
      run_frame({1'b1, 8'h12, 1'b0}, 16, 1'b0, "gate f1", got);
      begin
        repeat (70) @(negedge clk);
        en = 1'b0;
      end
    join
    frame_end("gate f1", 1'b1);
    check("gate retained", 32'(level), 32'd1);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (!txd) lows++;
    end
    check("gate held idle", 32'(lows), 32'd0);
    check("gate busy held", 32'(busy), 32'd1);
    en = 1'b1;
    @(posedge clk);
    run_frame({1'b1, 8'h34, 1'b0}, 16, 1'b0, "gate f2", got);
    frame_end("gate f2", 1'b0);

    baud = 20'd32;
    push2(8'h5A, 8'h96);
    fork
      run_frame({1'b1, 8'h5A, 1'b0}, 32, 1'b0, "div32", got);
      begin
        repeat (100) @(negedge clk);
        baud = 20'd64;
      end
    join
    run_frame({1'b1, 8'h96, 1'b0}, 64, 1'b1, "div64", got);
    frame_end("div64", 1'b0);

    baud = 20'd16;
    push2(8'hA5, 8'hC3);
    repeat (41) @(negedge clk);
    check("abort pre-reset txd", 32'(txd), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort async txd", 32'(txd), 32'd1);
    check("abort level", 32'(level), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (!txd) lows++;
    end
    check("abort stays idle", 32'(lows), 32'd0);
    check("abort busy after release", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/aha_uart_tx_driver.md
Name: aha_uart_tx_driver

Overview:
- Synthesizable UART 8N1 transmitter.
- It is the sending end of the serial link that the SWO/UART capture block samples. It drives UARTx_RXD from a byte stream, so the SoC receive path can be exercised without a loopback.
- Bytes enter through a valid/ready handshake into a small FIFO. They are serialized LSB-first at a programmable bit period.
- Intended for test-soc benches and for reuse as a debug-console stimulus source.

Parameters:
- FIFO_DEPTH, 4: number of queued bytes; must be a power of two, ≥2.
- DIV_WIDTH, 20: width of the BAUDDIV input.

Ports:
- CLK  input  1  block clock (same domain as uart0_clk)
- RESETn  input  1  asynchronous active-low reset
- ENABLE  input  1  1 = may start new frames; 0 = finish the current frame, then hold idle
- BAUDDIV  input  DIV_WIDTH  clock cycles per bit; values <16 are treated as 16
- IN_VALID  input  1  byte offered
- IN_DATA  input  8  byte to send
- IN_READY  output  1  FIFO can accept a byte
- TXD  output  1  serial line, idle high
- BUSY  output  1  frame in progress or FIFO non-empty
- TX_DONE  output  1  one-cycle pulse at the end of each stop bit
- FIFO_LEVEL  output  clog2(FIFO_DEPTH)+1  bytes queued

Behaviour:
Reset (asynchronous, RESETn=0):
- TXD=1, IN_READY=1, BUSY=0, TX_DONE=0, FIFO_LEVEL=0.
- FSM goes to IDLE; FIFO pointers, bit counter and divider counter clear.
- Reset mid-frame aborts the frame immediately; TXD returns high asynchronously.

Handshake:
- A byte is accepted on any rising CLK edge where IN_VALID & IN_READY.
- IN_READY = !full. It is registered-free combinational from the FIFO level.
- No push occurs when full, even if a pop happens in the same cycle.
- A push and a pop in the same cycle leave FIFO_LEVEL unchanged.
- IN_DATA must be stable while IN_VALID=1 and IN_READY=0.

FSM states: IDLE, START, DATA, STOP.
- IDLE: TXD=1. If ENABLE & FIFO non-empty, pop the head byte into the shift register, latch the effective BAUDDIV (max(BAUDDIV,16)), load the divider, and go to START.
- START: TXD=0 for exactly div cycles, then go to DATA with bit index 0.
- DATA: TXD=shift[0] for div cycles per bit, shifting right after each bit. After bit 7 completes, go to STOP.
- STOP: TXD=1 for div cycles. On the last cycle, pulse TX_DONE. If ENABLE & FIFO non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.

Timing:
- TXD is a registered output.
- A byte accepted at edge k into an empty FIFO with the FSM in IDLE drives TXD low from edge k+1.
- A frame lasts exactly 10×div cycles; back-to-back frames have no gap.

Other rules:
- BAUDDIV changes are ignored until the next frame start.
- ENABLE deasserted mid-frame: the frame completes normally and the FIFO contents are retained.
- BUSY = (state≠IDLE) | (FIFO_LEVEL≠0).
- The divider counts down from div-1 to 0. The bit counter is 3 bits and wraps only at a state change.

Decomposition:
- aha_uart_pkg:
  - tx_state_e enum {IDLE, START, DATA, STOP}
  - localparam MIN_BAUDDIV=16
  - localparam FRAME_BITS=10
- Sub-module aha_sync_fifo (#(WIDTH=8, DEPTH=FIFO_DEPTH)):
  - push/pop/full/empty/level interface
  - asynchronous active-low reset, single clock
- The FSM, divider and shifter live in the top module.

Test Plan:
- Reset: hold RESETn=0 for 5 cycles → TXD=1, IN_READY=1, BUSY=0, FIFO_LEVEL=0. Assert RESETn=0 mid-DATA → TXD=1 within the same cycle and BUSY=0 after release.
- Single byte: BAUDDIV=16, send 0xA5 → TXD sequence per 16 cycles is 0,1,0,1,0,0,1,0,1,1. TX_DONE pulses once at cycle 160 after the start edge. The SWO capture decodes 0xA5.
- Clamp: BAUDDIV=3, send 0x00 → every bit lasts 16 cycles and the frame lasts 160 cycles.
- Back-to-back / full: with FIFO_DEPTH=4 and ENABLE=1, push 0x41,0x42,0x43,0x44,0x45 without a gap.
  - IN_READY drops after the 5th byte is offered (one byte popped, four queued).
  - Frames are contiguous with no idle high gap beyond the stop bits.
  - The capture prints "ABCDE".
- ENABLE gating: queue 2 bytes, deassert ENABLE during the first frame's bit 3 → the first frame completes and TXD stays high. FIFO_LEVEL=1 and BUSY=1. Re-asserting ENABLE starts the second frame on the next cycle.
- BAUDDIV change mid-frame: start a frame at BAUDDIV=32 and switch to 64 during DATA → the current frame lasts 320 cycles and the next frame lasts 640.
